// File: rtl/hp54542c_sync_lock_ctrl.sv
// Frame-lock controller: classifies LCD line-sync edges, verifies lines per frame, drives VGA timing enable/restart.
// Latency: sync rise to frame_start/lock_lost is 3 clocks; no backpressure (free-running levels and pulses).
module hp54542c_sync_lock_ctrl #(
  parameter int P_LINES       = 480,
  parameter int P_VGAP_MIN    = 1000,
  parameter int P_TIMEOUT     = 100000,
  parameter int P_LOCK_FRAMES = 2
) (
  input  logic       iw_clk,
  input  logic       iw_rst_n,
  input  logic       iw_sync,
  input  logic       iw_enable,
  output logic       ow_timing_en,
  output logic       ow_frame_start,
  output logic       ow_locked,
  output logic       ow_lock_lost,
  output logic [7:0] ow_err_count
);

  localparam logic [16:0] GAP_MAX  = 17'(P_TIMEOUT);
  localparam logic [16:0] GAP_VMIN = 17'(P_VGAP_MIN);
  localparam logic [9:0]  LINES    = 10'(P_LINES);
  localparam logic [3:0]  LOCK_N   = 4'(P_LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        rst_n;
  logic        sync_meta, sync_s, sync_prev, sync_edge;
  logic [16:0] gap_cnt;
  logic        armed;
  logic [9:0]  line_cnt;
  logic [3:0]  vcnt, vcnt_nxt, vcnt_inc;
  logic        frame_edge, line_edge, lines_ok, locked_err;
  logic        fs_nxt, ll_nxt, err_inc;

  // Async assert, release lands on the next clock so logic updates from the second edge.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) rst_n <= 1'b0;
    else           rst_n <= 1'b1;
  end

  always_ff @(posedge iw_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
      sync_prev <= 1'b0;
      sync_edge <= 1'b0;
    end else begin
      sync_meta <= iw_sync;
      sync_s    <= sync_meta;
      sync_prev <= sync_s;
      sync_edge <= sync_s & ~sync_prev;
    end
  end

  always_ff @(posedge iw_clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (sync_edge) begin
      gap_cnt <= '0;
    end else if (gap_cnt < GAP_MAX) begin
      gap_cnt <= gap_cnt + 17'd1;
    end
  end

  // The first edge after arming may follow an arbitrarily long gap, so it only arms.
  always_ff @(posedge iw_clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (state == ST_IDLE) begin
      armed <= 1'b0;
    end else if (sync_edge) begin
      armed <= 1'b1;
    end
  end

  assign frame_edge = sync_edge & armed & (gap_cnt > GAP_VMIN);
  assign line_edge  = sync_edge & armed & ~(gap_cnt > GAP_VMIN);

  always_ff @(posedge iw_clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt <= '0;
    end else if (frame_edge) begin
      line_cnt <= 10'd1;
    end else if (line_edge && (line_cnt != 10'h3FF)) begin
      line_cnt <= line_cnt + 10'd1;
    end
  end

  assign lines_ok   = (line_cnt == LINES);
  assign vcnt_inc   = vcnt + 4'd1;
  assign locked_err = (frame_edge & ~lines_ok) | (line_edge & lines_ok) | (gap_cnt == GAP_MAX);

  always_comb begin
    state_nxt = state;
    vcnt_nxt  = vcnt;
    fs_nxt    = 1'b0;
    ll_nxt    = 1'b0;
    err_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iw_enable) state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (frame_edge) begin
          state_nxt = ST_VERIFY;
          vcnt_nxt  = '0;
        end
      end
      ST_VERIFY: begin
        if (frame_edge) begin
          if (lines_ok) begin
            vcnt_nxt = vcnt_inc;
            if (vcnt_inc == LOCK_N) begin
              state_nxt = ST_LOCKED;
              fs_nxt    = 1'b1;
            end
          end else begin
            vcnt_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (locked_err) begin
          state_nxt = ST_SEARCH;
          ll_nxt    = 1'b1;
          err_inc   = 1'b1;
        end else if (frame_edge) begin
          fs_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Disable overrides everything, including a coincident error.
    if (!iw_enable) begin
      state_nxt = ST_IDLE;
      fs_nxt    = 1'b0;
      ll_nxt    = 1'b0;
      err_inc   = 1'b0;
    end
  end

  always_ff @(posedge iw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      vcnt           <= '0;
      ow_frame_start <= 1'b0;
      ow_lock_lost   <= 1'b0;
      ow_err_count   <= '0;
    end else begin
      state          <= state_nxt;
      vcnt           <= vcnt_nxt;
      ow_frame_start <= fs_nxt;
      ow_lock_lost   <= ll_nxt;
      if (err_inc && (ow_err_count != 8'hFF)) begin
        ow_err_count <= ow_err_count + 8'd1;
      end
    end
  end

  assign ow_locked    = (state == ST_LOCKED);
  assign ow_timing_en = (state == ST_LOCKED);

endmodule

// File: tb/tb_hp54542c_sync_lock_ctrl.sv
// Directed bench for the frame-lock controller with scaled-down frame geometry.
module tb_hp54542c_sync_lock_ctrl;

  localparam int LINES   = 8;
  localparam int VGAP    = 30;
  localparam int TMO     = 200;
  localparam int LOCKF   = 2;
  localparam int LPER    = 10;
  localparam int GAP     = 60;

  logic       iw_clk = 1'b0;
  logic       iw_rst_n = 1'b0;
  logic       iw_sync = 1'b0;
  logic       iw_enable = 1'b0;
  logic       ow_timing_en;
  logic       ow_frame_start;
  logic       ow_locked;
  logic       ow_lock_lost;
  logic [7:0] ow_err_count;

  hp54542c_sync_lock_ctrl #(
    .P_LINES(LINES), .P_VGAP_MIN(VGAP), .P_TIMEOUT(TMO), .P_LOCK_FRAMES(LOCKF)
  ) dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_sync(iw_sync), .iw_enable(iw_enable),
    .ow_timing_en(ow_timing_en), .ow_frame_start(ow_frame_start), .ow_locked(ow_locked),
    .ow_lock_lost(ow_lock_lost), .ow_err_count(ow_err_count)
  );

  always #5 iw_clk = ~iw_clk;

  typedef struct {
    bit is_ll;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  tcyc  = 0;
  int  last_drive = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock; samples at the falling edge and matches any output pulse against the scoreboard.
  task automatic tick();
    ev_t e;
    @(negedge iw_clk);
    tcyc++;
    if (ow_frame_start === 1'b1 || ow_lock_lost === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL sb_unexpected: observed fs=%0b ll=%0b at cycle %0d, required no pulse",
               ow_frame_start, ow_lock_lost, tcyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        assert (ow_frame_start === !e.is_ll && ow_lock_lost === e.is_ll && tcyc == e.cyc) else begin
          fails++;
          $error("FAIL sb_event: observed fs=%0b ll=%0b cyc=%0d, required fs=%0b ll=%0b cyc=%0d",
                 ow_frame_start, ow_lock_lost, tcyc, !e.is_ll, e.is_ll, e.cyc);
        end
        tests++;
        assert (ow_locked === !e.is_ll && ow_timing_en === !e.is_ll) else begin
          fails++;
          $error("FAIL lock_level: observed locked=%0b timing_en=%0b, required %0b",
                 ow_locked, ow_timing_en, !e.is_ll);
        end
      end
    end
  endtask

  task automatic push_ev(input bit is_ll, input int cyc);
    ev_t e;
    e.is_ll = is_ll;
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  // Gap, then nlines pulses at LPER spacing. Sync rising before posedge k shows its output 4 ticks later.
  task automatic send_frame(input int nlines, input bit fs_first, input int ll_idx);
    repeat (GAP) tick();
    for (int i = 0; i < nlines; i++) begin
      iw_sync = 1'b1;
      last_drive = tcyc;
      if (i == 0 && fs_first) push_ev(1'b0, tcyc + 4);
      if (i == ll_idx)        push_ev(1'b1, tcyc + 4);
      tick();
      tick();
      iw_sync = 1'b0;
      repeat (LPER - 2) tick();
    end
  endtask

  task automatic drain(input string tag);
    repeat (8) tick();
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic acquire(input string tag);
    send_frame(LINES, 1'b0, -1);  // arming
    send_frame(LINES, 1'b0, -1);  // SEARCH -> VERIFY
    send_frame(LINES, 1'b0, -1);  // first good frame
    send_frame(LINES, 1'b1, -1);  // second good frame locks
    drain(tag);
    chk({tag, "_locked"}, ow_locked, 1);
    chk({tag, "_timing_en"}, ow_timing_en, 1);
  endtask

  initial begin
    // Reset held with sync toggling
    for (int i = 0; i < 6; i++) begin
      iw_sync = ~iw_sync;
      @(negedge iw_clk);
    end
    iw_sync = 1'b0;
    chk("rst_timing_en", ow_timing_en, 0);
    chk("rst_frame_start", ow_frame_start, 0);
    chk("rst_locked", ow_locked, 0);
    chk("rst_lock_lost", ow_lock_lost, 0);
    chk("rst_err_count", ow_err_count, 0);

    // Released but disabled: frames must not produce anything
    iw_rst_n = 1'b1;
    send_frame(LINES, 1'b0, -1);
    send_frame(LINES, 1'b0, -1);
    send_frame(LINES, 1'b0, -1);
    drain("idle_no_pulse");
    chk("idle_locked", ow_locked, 0);
    chk("idle_err", ow_err_count, 0);

    // Acquisition followed by steady lock
    iw_enable = 1'b1;
    acquire("acq");
    send_frame(LINES, 1'b1, -1);
    send_frame(LINES, 1'b1, -1);
    drain("steady");

    // Short frame: its start edge is still good, the next one reports the error
    send_frame(LINES - 1, 1'b1, -1);
    send_frame(LINES, 1'b0, 0);
    drain("short_ll");
    chk("short_err", ow_err_count, 1);
    chk("short_timing_en", ow_timing_en, 0);
    send_frame(LINES, 1'b0, -1);
    send_frame(LINES, 1'b0, -1);
    send_frame(LINES, 1'b1, -1);
    drain("relock_short");
    chk("relock_short_locked", ow_locked, 1);

    // Long frame: the extra line edge errors at once
    send_frame(LINES + 1, 1'b1, LINES);
    drain("long_ll");
    chk("long_err", ow_err_count, 2);
    send_frame(LINES, 1'b0, -1);
    send_frame(LINES, 1'b0, -1);
    send_frame(LINES, 1'b1, -1);
    drain("relock_long");
    chk("relock_long_locked", ow_locked, 1);

    // Timeout: sync stops; gap reaches TMO at tick last+4+TMO, lock_lost follows one tick later
    push_ev(1'b1, last_drive + 5 + TMO);
    repeat (TMO + 20) tick();
    drain("timeout_ll");
    chk("timeout_err", ow_err_count, 3);
    chk("timeout_locked", ow_locked, 0);

    // Disable in VERIFY: re-enable must re-arm and fully reacquire
    send_frame(LINES, 1'b0, -1);
    send_frame(LINES, 1'b0, -1);
    iw_enable = 1'b0;
    repeat (20) tick();
    drain("dis_verify");
    chk("dis_verify_err", ow_err_count, 3);
    iw_enable = 1'b1;
    acquire("reacq_v");

    // Disable while locked
    iw_enable = 1'b0;
    tick();
    chk("dis_locked_locked", ow_locked, 0);
    chk("dis_locked_timing_en", ow_timing_en, 0);
    chk("dis_locked_ll", ow_lock_lost, 0);
    drain("dis_locked");
    chk("dis_locked_err", ow_err_count, 3);
    iw_enable = 1'b1;
    acquire("reacq_l");

    // Async reset while locked
    iw_rst_n = 1'b0;
    #1;
    chk("arst_err", ow_err_count, 0);
    chk("arst_locked", ow_locked, 0);
    chk("arst_timing_en", ow_timing_en, 0);
    repeat (4) tick();
    iw_rst_n = 1'b1;
    repeat (4) tick();
    chk("post_arst_err", ow_err_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hp54542c_sync_lock_ctrl.md
# hp54542c_sync_lock_ctrl

Frame-lock controller for the HP54542C LCD-to-VGA path. It watches the scope's LCD line-sync, tells line pulses from the vertical gap, and checks the line count per frame over several frames. It then drives the VGA timing generator: an enable level and a one-cycle counter-restart pulse at each verified frame start. On any framing violation it drops lock and reacquires.

## Interface

Parameters:
- P_LINES, 480: LCD sync pulses per frame (active lines).
- P_VGAP_MIN, 1000: an edge whose preceding gap exceeds this many clocks is a frame edge (line period 800, vertical gap ~36000).
- P_TIMEOUT, 100000: clocks without any sync edge, while locked, that force loss of lock.
- P_LOCK_FRAMES, 2: consecutive good frames required to lock (1..15).

Ports:
- iw_clk  in  1  pixel clock from LCD interface.
- iw_rst_n  in  1  reset, asynchronous, active-low.
- iw_sync  in  1  LCD line sync, asynchronous to iw_clk.
- iw_enable  in  1  controller run; low forces IDLE.
- ow_timing_en  out  1  enables the VGA timing generator; high only in LOCKED.
- ow_frame_start  out  1  one-cycle pulse that restarts the timing generator counter.
- ow_locked  out  1  state == LOCKED.
- ow_lock_lost  out  1  one-cycle pulse on exit from LOCKED due to an error.
- ow_err_count  out  8  loss-of-lock events, saturating at 255.

## Operation

- iw_sync passes through a 2-flop synchronizer, then a rising-edge detector ("edge").
- Gap counter: 17 bits, clears to 0 on the cycle after an edge, otherwise increments, saturating at P_TIMEOUT. The value on the edge cycle is the gap. A gap > P_VGAP_MIN gives a frame edge; otherwise a line edge.
- Armed flag: cleared by reset and in IDLE, set by the first edge. While it is clear, edges are not classified and only set the flag.
- Line counter: 10 bits. A frame edge loads 1. A line edge increments it, saturating at 1023.
- States:
  - IDLE: entered from any state when iw_enable = 0 (no ow_lock_lost, count unchanged). Goes to SEARCH when iw_enable = 1.
  - SEARCH: a frame edge moves to VERIFY and clears the verify count (4 bits).
  - VERIFY: on a frame edge, check the line count held just before that edge.
    - Count == P_LINES: increment the verify count. When it reaches P_LOCK_FRAMES, go to LOCKED and pulse ow_frame_start on the same cycle.
    - Count != P_LINES: clear the verify count and stay in VERIFY; this edge starts the new candidate frame.
  - LOCKED:
    - Frame edge with count == P_LINES: pulse ow_frame_start.
    - Frame edge with count != P_LINES: error.
    - Line edge when the count is already P_LINES: error (too many lines).
    - Gap counter reaching P_TIMEOUT: error.
    - Any error: pulse ow_lock_lost, increment ow_err_count (saturating), go to SEARCH. Armed stays set.
- If an error and iw_enable = 0 occur on the same cycle, IDLE wins and no error is counted.

## Timing

- Reset values: all outputs 0, state IDLE, all counters 0, armed clear.
- iw_sync high at rising iw_clk edge k causes the edge-detect cycle at k+2. State and output updates are registered at k+3. So ow_frame_start and ow_lock_lost are high for exactly the cycle after edge k+2 (fixed 3-clock latency).
- ow_timing_en and ow_locked go high in the same cycle as the locking ow_frame_start. They drop in the same cycle as ow_lock_lost.
- Timeout: ow_lock_lost is high in the cycle after the gap counter first equals P_TIMEOUT.
- Reset assertion mid-operation clears everything immediately. Deassertion is synchronized to iw_clk; the first state update occurs at the second iw_clk edge after release.

## Test plan

- Reset: hold iw_rst_n low with sync toggling → all outputs 0. Release with iw_enable = 0 → stays IDLE, outputs 0.
- Acquisition: iw_enable = 1, then frames of 480 sync pulses at an 800-clock period plus a 36000-clock gap → ow_locked rises on the 3rd frame edge, 3 clocks after the iw_sync rise, with ow_frame_start pulsed once. After that, one ow_frame_start per frame and none on line edges.
- Short frame while locked: a frame of 479 lines → one ow_lock_lost pulse on the next frame edge, ow_err_count = 1, ow_timing_en = 0. Three good frames later, locked again.
- Long frame: the 481st line edge while locked → immediate ow_lock_lost and ow_err_count increment.
- Timeout: stop iw_sync while locked → ow_lock_lost exactly 100000 clocks after the gap counter's clear cycle; ow_locked = 0.
- Disable mid-VERIFY and mid-LOCKED: iw_enable = 0 → IDLE next cycle, no ow_lock_lost, ow_err_count unchanged. Re-enable requires armed plus full reacquisition. An async reset pulse while LOCKED clears ow_err_count to 0.
